// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// A 32-step shift-add multiplier and a 32-step restoring divider share one
// 64-bit accumulator. Divide-by-zero and signed overflow skip the iterations.
//
// Handshake: start is a level request held by ID/EX until done. done is a
// one-cycle registered pulse that coincides with result/rdOut becoming valid.
// stall = start & ~done freezes the front of the pipeline until then, so a
// single start assertion is exactly one operation. flush kills whatever is
// in flight (or refuses a request in IDLE) and never produces done.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  func3,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rdOut,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [63:0] acc_q, acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [31:0] mag_q, mag_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rdout_q, rdout_d;

    // Operand decode and magnitudes of the captured operands
    logic        is_div;
    logic        op1_signed;
    logic        op2_signed;
    logic [31:0] mag1;
    logic [31:0] mag2;

    always_comb begin
        is_div     = func3_q[2];
        op1_signed = (func3_q == F_MUL) || (func3_q == F_MULH) ||
                     (func3_q == F_MULHSU) || (func3_q == F_DIV) ||
                     (func3_q == F_REM);
        op2_signed = (func3_q == F_MUL) || (func3_q == F_MULH) ||
                     (func3_q == F_DIV) || (func3_q == F_REM);
        mag1 = (op1_signed && op1_q[31]) ? (~op1_q + 32'd1) : op1_q;
        mag2 = (op2_signed && op2_q[31]) ? (~op2_q + 32'd1) : op2_q;
    end

    // One iteration of shift-add multiply or restoring divide
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] calc_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        // Shifted remainder is {rem, next dividend bit}; a clear borrow
        // means the divisor fits and this quotient bit is 1.
        div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, mag_q};
        if (div_trial[32]) begin
            div_next = {acc_q[62:32], acc_q[31], acc_q[30:0], 1'b0};
        end else begin
            div_next = {div_trial[31:0], acc_q[30:0], 1'b1};
        end
        calc_next = is_div ? div_next : mul_next;
    end

    // Sign correction and result selection applied to the final iteration
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_res;

    always_comb begin
        prod_fix = neg_q ? (~calc_next + 64'd1) : calc_next;
        quo_fix  = neg_q ? (~calc_next[31:0] + 32'd1) : calc_next[31:0];
        rem_fix  = rem_neg_q ? (~calc_next[63:32] + 32'd1) : calc_next[63:32];
        case (func3_q)
            F_MUL:                    fin_res = prod_fix[31:0];
            F_MULH, F_MULHSU, F_MULHU: fin_res = prod_fix[63:32];
            F_DIV, F_DIVU:            fin_res = quo_fix;
            default:                  fin_res = rem_fix;
        endcase
    end

    // Special cases detected directly from the live request in IDLE
    logic        in_div0;
    logic        in_ovf;
    logic [31:0] special_res;

    always_comb begin
        in_div0 = func3[2] && (operand2 == 32'd0);
        // DIV (100) and REM (110) are the signed divides
        in_ovf  = func3[2] && !func3[0] &&
                  (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
        if (in_div0) begin
            special_res = func3[1] ? operand1 : 32'hFFFF_FFFF;
        end else begin
            special_res = func3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d   = state_q;
        func3_d   = func3_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rdout_d   = rdout_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    func3_d = func3;
                    op1_d   = operand1;
                    op2_d   = operand2;
                    rd_d    = rd;
                    if (in_div0 || in_ovf) begin
                        state_d  = S_FIN;
                        result_d = special_res;
                        rdout_d  = rd;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_PREP;
                    end
                end
            end
            S_PREP: begin
                mag_d     = is_div ? mag2 : mag1;
                acc_d     = {32'd0, is_div ? mag1 : mag2};
                neg_d     = (op1_signed & op1_q[31]) ^ (op2_signed & op2_q[31]);
                rem_neg_d = op1_signed & op1_q[31];
                cnt_d     = 5'd0;
                state_d   = S_CALC;
            end
            S_CALC: begin
                acc_d = calc_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = S_FIN;
                    result_d = fin_res;
                    rdout_d  = rd_q;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            rdout_d  = rdout_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= S_IDLE;
            func3_q   <= 3'd0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            rd_q      <= 5'd0;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            mag_q     <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
            rdout_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            func3_q   <= func3_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rdout_q   <= rdout_d;
        end
    end

    // Output mapping
    always_comb begin
        stall     = start & ~done_q;
        busy      = (state_q != S_IDLE);
        done      = done_q;
        result    = result_q;
        rdOut     = rdout_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: table-driven vectors, randomized ops checked
// against an arithmetic reference model, and hand-written flush/reset/
// back-to-back sequences.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        flush;
    logic [2:0]  func3;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  rd;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdOut;
    logic [1:0]  dbg_state;

    ex_muldiv_unit dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .flush     (flush),
        .func3     (func3),
        .operand1  (operand1),
        .operand2  (operand2),
        .rd        (rd),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rdOut     (rdOut),
        .dbg_state (dbg_state)
    );

    // Clock and cycle stamp
    int cyc_g = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model built on plain 64-bit and signed arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 32'd0)) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Driver: issue one op at the current cycle (cycle 0) and follow it to done.
    // Operand/func3/rd inputs are scrambled after accept to prove capture.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          input logic [31:0] exp_res, input int exp_lat,
                          output int start_cyc);
        int          lat;
        logic        stall_ok;
        logic        seen;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        func3    = f3;
        operand1 = a;
        operand2 = b;
        rd       = r;
        start    = 1'b1;
        exp_q.push_back(exp_res);
        exp_rd_q.push_back(r);
        start_cyc = cyc_g;
        #1;
        stall_ok = (stall === 1'b1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (stall !== 1'b1) stall_ok = 1'b0;
                operand1 = $urandom;
                operand2 = $urandom;
                func3    = 3'($urandom_range(0, 7));
                rd       = 5'($urandom_range(0, 31));
            end
        end
        if (!seen) chk({name, " timeout"}, 64'(seen), 64'd1);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " stall while waiting"}, 64'(stall_ok), 64'd1);
        if (seen) chk({name, " stall at done"}, 64'(stall), 64'd0);
        e_res = exp_q.pop_front();
        e_rd  = exp_rd_q.pop_front();
        if (seen) begin
            chk({name, " result"}, 64'(result), 64'(e_res));
            chk({name, " rdOut"}, 64'(rdOut), 64'(e_rd));
        end
        start = 1'b0;
    endtask

    initial begin
        int          sc0, sc1;
        logic [31:0] rb;
        logic [4:0]  rb_rd;
        logic        done_seen;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         34};
        vecs[8]  = '{3'd4, 32'h55,         32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'h1234,       32'd0,         5'd14, 32'h1234,      1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1};
        vecs[12] = '{3'd5, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd18, 32'd0,         34};
        vecs[14] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         5'd19, 32'hFFFF_FFFF, 34};
        vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd20, 32'd1,         34};
        vecs[16] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFD, 34};

        // Reset
        rstN = 1'b0; start = 1'b0; flush = 1'b0;
        func3 = 3'd0; operand1 = 32'd0; operand2 = 32'd0; rd = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset rdOut", 64'(rdOut), 64'd0);
        chk("reset state", 64'(dbg_state), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        rstN = 1'b1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r,
                   vecs[i].exp_res, vecs[i].exp_lat, sc0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done pulse/idle", i), 64'({done, busy}), 64'd0);
        end

        // Back-to-back DIVU: second accept in the cycle after done
        @(posedge clk);
        #1;
        run_op("b2b first", 3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 34, sc0);
        @(posedge clk);
        #1;
        run_op("b2b second", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 34, sc1);
        chk("b2b issue interval", 64'(sc1 - sc0), 64'd35);

        // Flush in cycle 10 of a MUL
        @(posedge clk);
        #1;
        rb    = result;
        rb_rd = rdOut;
        func3 = 3'd0; operand1 = 32'd123; operand2 = 32'd456; rd = 5'd22; start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("flush state idle", 64'(dbg_state), 64'd0);
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush result kept", 64'(result), 64'(rb));
        chk("flush rdOut kept", 64'(rdOut), 64'(rb_rd));
        done_seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        chk("flush no done", 64'(done_seen), 64'd0);

        // flush together with start in IDLE: not accepted
        start = 1'b1; flush = 1'b1; func3 = 3'd5; operand1 = 32'd9; operand2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush+start not accepted", 64'(busy), 64'd0);

        // Asynchronous reset in cycle 20 of a MUL
        @(posedge clk);
        #1;
        func3 = 3'd0; operand1 = 32'd11; operand2 = 32'd13; rd = 5'd23; start = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("pre-reset result nonzero", 64'(result != 32'd0), 64'd1);
        rstN = 1'b0;
        #1;
        chk("midop reset busy", 64'(busy), 64'd0);
        chk("midop reset done", 64'(done), 64'd0);
        chk("midop reset result", 64'(result), 64'd0);
        chk("midop reset rdOut", 64'(rdOut), 64'd0);
        chk("midop reset state", 64'(dbg_state), 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Randomized ops against the reference model
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            @(posedge clk);
            #1;
            run_op($sformatf("rand%0d f3=%0d a=%0h b=%0h", i, f3, a, b), f3, a, b,
                   5'($urandom_range(1, 31)), ref_res(f3, a, b), ref_lat(f3, a, b), sc0);
        end

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
